oam_accuracy_ctrl: RTL
======================

Name: oam_accuracy_ctrl

Overview:
- Run-time accuracy-mode controller for the OAM L3 approximate multiplier.
- Drives the two accuracy-enable lines (ACC_2, ACC_3) that select which constant-correction bits and partial-product columns are live.
- Gates operand issue into the multiplier pipeline. Enables change only after all in-flight operations drain, followed by a settle window, so no result mixes two accuracy configurations.

Parameters:
- MAX_INFLIGHT, 4: maximum outstanding multiplier operations (issued, result not yet returned).
- SETTLE_CYC, 2: idle cycles after an enable change before issue resumes; legal range 1..15.
- RESET_MODE, 2: mode loaded at reset; 0 = ACC_1 only, 1 = ACC_1+ACC_2, 2 = full ACC_3.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- mode_req_valid, in, 1: mode-change request valid.
- mode_req, in, 2: requested mode, 0..2; 3 is illegal.
- mode_req_ready, out, 1: request accepted this cycle when high together with valid.
- in_valid, in, 1: upstream operand valid.
- in_ready, out, 1: controller allows issue.
- mul_in_valid, out, 1: operand issued to multiplier; equals in_valid && in_ready (combinational).
- mul_out_valid, in, 1: multiplier result returned; one per issued operand.
- acc_enable, out, 2: registered enables, [0] = ACC_2, [1] = ACC_3.
- mode_cur, out, 2: registered current mode.
- busy, out, 1: high in any state other than RUN.
- switch_done, out, 1: one-cycle pulse when a request completes.
- err, out, 1: sticky error flag; cleared only by reset.

Behaviour:
Mode-to-enable mapping (acc_enable[1] implies acc_enable[0]):
- Mode 0 -> 2'b00.
- Mode 1 -> 2'b01.
- Mode 2 -> 2'b11.

Reset (async assert, sync release by design flow):
- State = RUN; mode_cur = RESET_MODE; acc_enable = map(RESET_MODE).
- inflight = 0; settle counter = 0; switch_done = 0; err = 0.

Inflight counter:
- Width clog2(MAX_INFLIGHT+1).
- Increments on mul_in_valid, decrements on mul_out_valid; both in the same cycle leaves it unchanged.
- mul_out_valid while inflight == 0: counter holds at 0, err set.

FSM states: RUN, DRAIN, SWITCH, SETTLE.

RUN:
- in_ready = (inflight < MAX_INFLIGHT) || mul_out_valid.
- mode_req_ready = 1.
- On accept of mode_req == mode_cur: stay in RUN; switch_done pulses the next cycle.
- On accept of mode_req == 3: request dropped, err set, no pulse, stay in RUN.
- On accept of any other mode: latch target mode -> DRAIN.
- in_valid and mode_req accepted in the same cycle: the operand issues with the old mode, and the counter includes it.

DRAIN:
- in_ready = 0; mode_req_ready = 0.
- Move to SWITCH in the cycle after inflight reaches 0; also when entering DRAIN with inflight already 0.

SWITCH (1 cycle):
- acc_enable and mode_cur load the target at the end of this cycle.
- Load settle counter = SETTLE_CYC; -> SETTLE.

SETTLE:
- in_ready = 0; mode_req_ready = 0.
- Counter decrements each cycle; at 1 -> RUN, and switch_done pulses on the first RUN cycle.

Minimum switch cost with an empty pipe: 1 (DRAIN) + 1 (SWITCH) + SETTLE_CYC cycles before in_ready is asserted again.

Reset mid-operation: any state returns immediately to the reset values, and the pending target is discarded.

Test Plan:
- Reset mode: reset with RESET_MODE = 2 -> acc_enable = 2'b11, mode_cur = 2, in_ready = 1, busy = 0, err = 0.
- Drain-then-switch: issue 3 operands (inflight = 3), then request mode 0 -> busy rises, in_ready = 0, acc_enable stays 2'b11. After 3 results return: SWITCH, then 2 SETTLE cycles, acc_enable = 2'b00, switch_done pulses once, in_ready = 1.
- Inflight limit: 4 operands issued with no results -> in_ready = 0. One mul_out_valid -> same-cycle issue allowed, inflight stays 4.
- Same-mode and illegal requests: request mode 2 while in mode 2 -> switch_done pulse one cycle later, no busy. Request mode 3 -> err = 1 (sticky), mode unchanged.
- Edge cases:
  - Spurious result: mul_out_valid with inflight = 0 -> err = 1, counter stays 0.
  - Simultaneous issue and request in one cycle: the operand counted, then drained before the switch.
- Reset mid-switch: assert rst_n low during SETTLE -> outputs revert to reset values asynchronously, and no switch_done pulse occurs after release.

Source files
------------

// File: rtl/oam_accuracy_ctrl.sv
// Accuracy-mode controller for the OAM L3 approximate multiplier.
// Enable changes happen only once the pipe is empty, followed by a settle window.
module oam_accuracy_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int SETTLE_CYC   = 2,
  parameter int RESET_MODE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_req_valid,
  input  logic [1:0] mode_req,
  output logic       mode_req_ready,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       mul_in_valid,
  input  logic       mul_out_valid,
  output logic [1:0] acc_enable,
  output logic [1:0] mode_cur,
  output logic       busy,
  output logic       switch_done,
  output logic       err
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_IF   = IW'(MAX_INFLIGHT);
  localparam logic [3:0]    SETTLE_V = 4'(SETTLE_CYC);
  localparam logic [1:0]    RST_MODE = 2'(RESET_MODE);

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH, SETTLE} state_e;

  function automatic logic [1:0] mode_map(input logic [1:0] m);
    case (m)
      2'd0:    mode_map = 2'b00;
      2'd1:    mode_map = 2'b01;
      default: mode_map = 2'b11;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    target_q, target_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    acc_q, acc_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [3:0]    settle_q, settle_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          req_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      target_q   <= RST_MODE;
      mode_q     <= RST_MODE;
      acc_q      <= mode_map(RST_MODE);
      inflight_q <= '0;
      settle_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      inflight_q <= inflight_d;
      settle_q   <= settle_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_acc = mode_req_valid && mode_req_ready;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      RUN: if (req_acc && mode_req != 2'd3 && mode_req != mode_q) begin
        target_d = mode_req;
        state_d  = DRAIN;
      end
      DRAIN:   if (inflight_q == '0) state_d = SWITCH;
      SWITCH:  state_d = SETTLE;
      SETTLE:  if (settle_q <= 4'd1) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready       = 1'b0;
    mode_req_ready = 1'b0;
    busy           = (state_q != RUN);
    if (state_q == RUN) begin
      in_ready       = (inflight_q < MAX_IF) || mul_out_valid;
      mode_req_ready = 1'b1;
    end
  end

  assign mul_in_valid = in_valid && in_ready;

  // Datapath: inflight tracking, enable load, settle timer, status flags
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    settle_d   = settle_q;
    done_d     = 1'b0;

    if (mul_out_valid && inflight_q == '0) err_d = 1'b1;
    if (mul_in_valid && !mul_out_valid)
      inflight_d = inflight_q + 1'b1;
    else if (!mul_in_valid && mul_out_valid && inflight_q != '0)
      inflight_d = inflight_q - 1'b1;

    case (state_q)
      RUN: if (req_acc) begin
        if (mode_req == 2'd3)         err_d  = 1'b1;
        else if (mode_req == mode_q)  done_d = 1'b1;
      end
      SWITCH: begin
        mode_d   = target_q;
        acc_d    = mode_map(target_q);
        settle_d = SETTLE_V;
      end
      SETTLE: begin
        if (settle_q != '0) settle_d = settle_q - 1'b1;
        if (settle_q <= 4'd1) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign acc_enable  = acc_q;
  assign mode_cur    = mode_q;
  assign switch_done = done_q;
  assign err         = err_q;
endmodule
